// File: rtl/sirv_apb_mst_arb2_pkg.sv
// Shared types for the two-requester APB master controller.
package sirv_apb_mst_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Width of the ACCESS-phase timeout counter; at least one bit.
    function automatic int tout_w(int tout);
        return (tout < 1) ? 1 : $clog2(tout + 1);
    endfunction

endpackage

// File: rtl/sirv_apb_mst_arb2_if.sv
// Requester command/response ports and the APB master bus, bundled.
interface sirv_apb_mst_arb2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_write;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;
    logic          rsp0_err;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_write;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;
    logic          rsp1_err;

    logic [AW-1:0] apb_paddr;
    logic          apb_pwrite;
    logic          apb_pselx;
    logic          apb_penable;
    logic [DW-1:0] apb_pwdata;
    logic [DW-1:0] apb_prdata;
    logic          apb_pready;
    logic          apb_pslverr;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output apb_paddr, apb_pwrite, apb_pselx, apb_penable, apb_pwdata,
        input  apb_prdata, apb_pready, apb_pslverr
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  apb_paddr, apb_pwrite, apb_pselx, apb_penable, apb_pwdata,
        output apb_prdata, apb_pready, apb_pslverr
    );
endinterface

// File: rtl/sirv_apb_rr_arb2.sv
// Two-way round-robin grant; last_grant moves only when a command is accepted.
module sirv_apb_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant,
    output logic       any
);
    logic last_grant;

    assign any = |valid;

    always_comb begin
        grant = 1'b0;
        unique case (valid)
            2'b11:   grant = ~last_grant;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end
endmodule

// File: rtl/sirv_apb_mst_arb2.sv
// Two-requester APB master: round-robin accept, SETUP/ACCESS sequencing,
// PREADY wait states, ACCESS timeout and registered per-requester responses.
module sirv_apb_mst_arb2
    import sirv_apb_mst_arb2_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int TOUT_CYC = 64
) (
    input logic                 clk,
    input logic                 rst,
    sirv_apb_mst_arb2_if.master bus
);
    localparam int CW = tout_w(TOUT_CYC);
    localparam logic [CW-1:0] TLAST = (TOUT_CYC == 0) ? '0 : CW'(TOUT_CYC - 1);

    state_t        state;
    state_t        nxt;
    logic [CW-1:0] cnt;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [DW-1:0] wdata_q;
    logic          sel_q;
    logic          rsp_v;
    logic          rsp_sel;
    logic          rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          grant;
    logic          any;
    logic          accept;
    logic          done;
    logic          tout_hit;

    sirv_apb_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .accept (accept),
        .grant  (grant),
        .any    (any)
    );

    assign tout_hit = (TOUT_CYC != 0) && (cnt == TLAST);

    always_comb begin
        nxt    = state;
        accept = 1'b0;
        done   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (any) begin
                    accept = 1'b1;
                    nxt    = ST_SETUP;
                end
            end
            ST_SETUP:  nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.apb_pready || tout_hit) begin
                    done = 1'b1;
                    nxt  = ST_IDLE;
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            sel_q     <= 1'b0;
            rsp_v     <= 1'b0;
            rsp_sel   <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q  <= grant ? bus.req1_addr  : bus.req0_addr;
                write_q <= grant ? bus.req1_write : bus.req0_write;
                wdata_q <= grant ? bus.req1_wdata : bus.req0_wdata;
                sel_q   <= grant;
            end
            if (state == ST_ACCESS && !done) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            // PREADY takes priority over a timeout landing in the same cycle.
            rsp_v     <= done;
            rsp_sel   <= sel_q;
            rsp_err   <= done && (bus.apb_pready ? bus.apb_pslverr : 1'b1);
            rsp_rdata <= (done && bus.apb_pready && !write_q) ? bus.apb_prdata : '0;
        end
    end

    assign bus.req0_ready  = accept && !grant;
    assign bus.req1_ready  = accept && grant;
    assign bus.apb_paddr   = addr_q;
    assign bus.apb_pwrite  = write_q;
    assign bus.apb_pwdata  = wdata_q;
    assign bus.apb_pselx   = (state != ST_IDLE);
    assign bus.apb_penable = (state == ST_ACCESS);
    assign bus.rsp0_valid  = rsp_v && !rsp_sel;
    assign bus.rsp1_valid  = rsp_v && rsp_sel;
    assign bus.rsp0_err    = bus.rsp0_valid && rsp_err;
    assign bus.rsp1_err    = bus.rsp1_valid && rsp_err;
    assign bus.rsp0_rdata  = bus.rsp0_valid ? rsp_rdata : '0;
    assign bus.rsp1_rdata  = bus.rsp1_valid ? rsp_rdata : '0;
endmodule

// File: tb/tb_sirv_apb_mst_arb2.sv
// Directed bench: dut_a uses the default timeout, dut_b uses TOUT_CYC=4.
module tb_sirv_apb_mst_arb2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sirv_apb_mst_arb2_if #(.AW(32), .DW(32)) a ();
    sirv_apb_mst_arb2_if #(.AW(32), .DW(32)) b ();

    sirv_apb_mst_arb2 #(.AW(32), .DW(32), .TOUT_CYC(64)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    sirv_apb_mst_arb2 #(.AW(32), .DW(32), .TOUT_CYC(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    // Status vector: {ready0, ready1, pselx, penable, rsp0_v, rsp1_v, err0, err1}
    function automatic logic [7:0] st_a();
        return {a.req0_ready, a.req1_ready, a.apb_pselx, a.apb_penable,
                a.rsp0_valid, a.rsp1_valid, a.rsp0_err, a.rsp1_err};
    endfunction

    function automatic logic [7:0] st_b();
        return {b.req0_ready, b.req1_ready, b.apb_pselx, b.apb_penable,
                b.rsp0_valid, b.rsp1_valid, b.rsp0_err, b.rsp1_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b0) begin
            errors++; $display("FAIL reset_st_a got %b exp %b", st_a(), 8'b0);
        end
        checks++;
        if (st_b() !== 8'b0) begin
            errors++; $display("FAIL reset_st_b got %b exp %b", st_b(), 8'b0);
        end
        checks++;
        if ({a.apb_paddr, a.apb_pwdata, a.apb_pwrite, a.rsp0_rdata, a.rsp1_rdata} !== 129'b0) begin
            errors++; $display("FAIL reset_data got %h %h %b exp 0", a.apb_paddr, a.apb_pwdata, a.apb_pwrite);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_contention();
        for (int c = 0; c < 13; c++) begin : cyc
            int p;
            int i;
            logic g;
            logic pg;
            logic [7:0] exp;
            if (c > 0) step();
            if (c == 0) begin
                a.req0_valid = 1'b1; a.req0_write = 1'b0; a.req0_addr = 32'h100;
                a.req1_valid = 1'b1; a.req1_write = 1'b0; a.req1_addr = 32'h200;
                a.apb_pready = 1'b1; a.apb_prdata = 32'h0000_1234;
            end
            if (c == 12) begin
                a.req0_valid = 1'b0;
                a.req1_valid = 1'b0;
            end
            @(negedge clk);
            p = c % 3;
            i = c / 3;
            g = i[0];
            pg = ~g;
            exp = 8'b0;
            if (p == 0 && c < 12) exp[7-int'(g)] = 1'b1;
            if (p != 0) exp[5] = 1'b1;
            if (p == 2) exp[4] = 1'b1;
            if (p == 0 && c > 0) exp[3-int'(pg)] = 1'b1;
            checks++;
            if (st_a() !== exp) begin
                errors++; $display("FAIL contention_c%0d got %b exp %b", c, st_a(), exp);
            end
            if (p == 1) begin
                checks++;
                if (a.apb_paddr !== (g ? 32'h200 : 32'h100)) begin
                    errors++; $display("FAIL contention_addr_c%0d got %h exp %h", c, a.apb_paddr, g ? 32'h200 : 32'h100);
                end
            end
            if (p == 0 && c > 0) begin
                checks++;
                if ((pg ? a.rsp1_rdata : a.rsp0_rdata) !== 32'h0000_1234) begin
                    errors++; $display("FAIL contention_rdata_c%0d got %h exp %h", c, pg ? a.rsp1_rdata : a.rsp0_rdata, 32'h1234);
                end
            end
        end
    endtask

    task automatic test_single_read();
        step();
        a.req0_valid = 1'b1; a.req0_write = 1'b0; a.req0_addr = 32'h10;
        a.apb_pready = 1'b1; a.apb_prdata = 32'hA5A5_0001;
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b1000_0000) begin
            errors++; $display("FAIL rd_accept got %b exp %b", st_a(), 8'b1000_0000);
        end
        step();
        a.req0_valid = 1'b0; a.req0_addr = 32'hFFF;
        @(negedge clk);
        checks++;
        if ({st_a(), a.apb_paddr, a.apb_pwrite} !== {8'b0010_0000, 32'h10, 1'b0}) begin
            errors++; $display("FAIL rd_setup got %b %h %b exp 00100000 00000010 0", st_a(), a.apb_paddr, a.apb_pwrite);
        end
        step();
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b0011_0000) begin
            errors++; $display("FAIL rd_access got %b exp %b", st_a(), 8'b0011_0000);
        end
        step();
        @(negedge clk);
        checks++;
        if ({st_a(), a.rsp0_rdata} !== {8'b0000_1000, 32'hA5A5_0001}) begin
            errors++; $display("FAIL rd_rsp got %b %h exp 00001000 a5a50001", st_a(), a.rsp0_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if ({st_a(), a.rsp0_rdata, a.apb_paddr} !== {8'b0, 32'h0, 32'h10}) begin
            errors++; $display("FAIL rd_idle got %b %h %h exp 0 0 10", st_a(), a.rsp0_rdata, a.apb_paddr);
        end
    endtask

    task automatic test_wait_err();
        step();
        a.apb_pready = 1'b0; a.apb_pslverr = 1'b0; a.apb_prdata = 32'hFFFF_FFFF;
        a.req1_valid = 1'b1; a.req1_write = 1'b1;
        a.req1_addr = 32'h20; a.req1_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b0100_0000) begin
            errors++; $display("FAIL we_accept got %b exp %b", st_a(), 8'b0100_0000);
        end
        step();
        a.req1_valid = 1'b0; a.req1_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if ({st_a(), a.apb_paddr, a.apb_pwdata, a.apb_pwrite} !== {8'b0010_0000, 32'h20, 32'hDEAD_BEEF, 1'b1}) begin
            errors++; $display("FAIL we_setup got %b %h %h %b", st_a(), a.apb_paddr, a.apb_pwdata, a.apb_pwrite);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 5) begin
                a.apb_pready = 1'b1; a.apb_pslverr = 1'b1;
            end
            @(negedge clk);
            checks++;
            if ({st_a(), a.apb_paddr, a.apb_pwdata, a.apb_pwrite} !== {8'b0011_0000, 32'h20, 32'hDEAD_BEEF, 1'b1}) begin
                errors++; $display("FAIL we_access%0d got %b %h %h %b", k, st_a(), a.apb_paddr, a.apb_pwdata, a.apb_pwrite);
            end
        end
        step();
        a.apb_pslverr = 1'b0;
        @(negedge clk);
        checks++;
        if ({st_a(), a.rsp1_rdata} !== {8'b0000_0101, 32'h0}) begin
            errors++; $display("FAIL we_rsp got %b %h exp 00000101 0", st_a(), a.rsp1_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b0) begin
            errors++; $display("FAIL we_idle got %b exp 0", st_a());
        end
    endtask

    task automatic test_timeout();
        step();
        b.apb_pready = 1'b0; b.apb_pslverr = 1'b0; b.apb_prdata = 32'h1111_2222;
        b.req0_valid = 1'b1; b.req0_write = 1'b0; b.req0_addr = 32'h30;
        @(negedge clk);
        checks++;
        if (st_b() !== 8'b1000_0000) begin
            errors++; $display("FAIL to_accept got %b exp %b", st_b(), 8'b1000_0000);
        end
        step();
        b.req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (st_b() !== 8'b0010_0000) begin
            errors++; $display("FAIL to_setup got %b exp %b", st_b(), 8'b0010_0000);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clk);
            checks++;
            if (st_b() !== 8'b0011_0000) begin
                errors++; $display("FAIL to_access%0d got %b exp %b", k, st_b(), 8'b0011_0000);
            end
        end
        step();
        @(negedge clk);
        checks++;
        if ({st_b(), b.rsp0_rdata} !== {8'b0000_1010, 32'h0}) begin
            errors++; $display("FAIL to_rsp got %b %h exp 00001010 0", st_b(), b.rsp0_rdata);
        end
        step();
        @(negedge clk);
        checks++;
        if (st_b() !== 8'b0) begin
            errors++; $display("FAIL to_idle got %b exp 0", st_b());
        end
    endtask

    task automatic test_collision();
        step();
        b.apb_pready = 1'b0; b.apb_pslverr = 1'b0; b.apb_prdata = 32'h0000_5A5A;
        b.req1_valid = 1'b1; b.req1_write = 1'b0; b.req1_addr = 32'h34;
        @(negedge clk);
        checks++;
        if (st_b() !== 8'b0100_0000) begin
            errors++; $display("FAIL col_accept got %b exp %b", st_b(), 8'b0100_0000);
        end
        step();
        b.req1_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 3) b.apb_pready = 1'b1;
            @(negedge clk);
            checks++;
            if (st_b() !== 8'b0011_0000) begin
                errors++; $display("FAIL col_access%0d got %b exp %b", k, st_b(), 8'b0011_0000);
            end
        end
        step();
        b.apb_pready = 1'b0;
        @(negedge clk);
        checks++;
        if ({st_b(), b.rsp1_rdata} !== {8'b0000_0100, 32'h0000_5A5A}) begin
            errors++; $display("FAIL col_rsp got %b %h exp 00000100 00005a5a", st_b(), b.rsp1_rdata);
        end
    endtask

    task automatic test_reset_mid();
        step();
        a.apb_pready = 1'b0; a.apb_prdata = 32'h0000_7777;
        a.req0_valid = 1'b1; a.req0_write = 1'b0; a.req0_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b1000_0000) begin
            errors++; $display("FAIL rm_accept got %b exp %b", st_a(), 8'b1000_0000);
        end
        step();
        a.req0_valid = 1'b0;
        step();
        a.apb_pready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b0011_0000) begin
            errors++; $display("FAIL rm_access got %b exp %b", st_a(), 8'b0011_0000);
        end
        step();
        a.apb_pready = 1'b0;
        @(negedge clk);
        checks++;
        if ({st_a(), a.rsp0_rdata} !== {8'b0, 32'h0}) begin
            errors++; $display("FAIL rm_dropped got %b %h exp 0 0", st_a(), a.rsp0_rdata);
        end
        step();
        rst = 1'b0;
        a.req0_valid = 1'b1; a.req0_addr = 32'h50;
        a.req1_valid = 1'b1; a.req1_addr = 32'h60; a.req1_write = 1'b0;
        @(negedge clk);
        checks++;
        if (st_a() !== 8'b1000_0000) begin
            errors++; $display("FAIL rm_tie got %b exp %b", st_a(), 8'b1000_0000);
        end
        step();
        a.req0_valid = 1'b0; a.req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({st_a(), a.apb_paddr} !== {8'b0010_0000, 32'h50}) begin
            errors++; $display("FAIL rm_setup got %b %h exp 00100000 50", st_a(), a.apb_paddr);
        end
        step();
        a.apb_pready = 1'b1;
        step();
        a.apb_pready = 1'b0;
        @(negedge clk);
        checks++;
        if ({st_a(), a.rsp0_rdata} !== {8'b0000_1000, 32'h0000_7777}) begin
            errors++; $display("FAIL rm_rsp got %b %h exp 00001000 7777", st_a(), a.rsp0_rdata);
        end
    endtask

    initial begin
        a.req0_valid = 1'b0; a.req0_write = 1'b0; a.req0_addr = '0; a.req0_wdata = '0;
        a.req1_valid = 1'b0; a.req1_write = 1'b0; a.req1_addr = '0; a.req1_wdata = '0;
        a.apb_prdata = '0; a.apb_pready = 1'b0; a.apb_pslverr = 1'b0;
        b.req0_valid = 1'b0; b.req0_write = 1'b0; b.req0_addr = '0; b.req0_wdata = '0;
        b.req1_valid = 1'b0; b.req1_write = 1'b0; b.req1_addr = '0; b.req1_wdata = '0;
        b.apb_prdata = '0; b.apb_pready = 1'b0; b.apb_pslverr = 1'b0;
        test_reset();
        test_contention();
        test_single_read();
        test_wait_err();
        test_timeout();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sirv_apb_mst_arb2.md
Name: sirv_apb_mst_arb2

Overview:
- Two-requester APB master controller. Arbitrates round-robin between two simple command ports and sequences the APB SETUP/ACCESS phases toward one APB slave, such as the peripheral-side example slave.
- Adds PREADY wait handling and a programmable-length timeout, and returns read data and error status to the granted requester.
- Sits between the system peripheral interconnect and the APB peripheral cluster.

Parameters:
AW, 32, address width of requester and APB address buses
DW, 32, data width of requester and APB data buses
TOUT_CYC, 64, max ACCESS-phase cycles before forced error completion; 0 disables timeout

Ports:
clk  in  1  sole clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
req0_valid  in  1  requester 0 command valid
req0_ready  out  1  requester 0 command accepted (1-cycle pulse)
req0_write  in  1  1=write, 0=read
req0_addr  in  AW  command address
req0_wdata  in  DW  write data
rsp0_valid  out  1  response pulse to requester 0, no backpressure
rsp0_rdata  out  DW  read data (0 for writes/errors)
rsp0_err  out  1  PSLVERR or timeout
req1_*/rsp1_*  same set and widths as requester 0
apb_paddr  out  AW  APB address
apb_pwrite  out  1  APB write
apb_pselx  out  1  APB select
apb_penable  out  1  APB enable
apb_pwdata  out  DW  APB write data
apb_prdata  in  DW  APB read data
apb_pready  in  1  APB ready
apb_pslverr  in  1  APB slave error

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0; last_grant=1, so requester 0 wins the first tie. Reset asserted mid-transfer drops PSELx/PENABLE the next cycle and issues no response.
- FSM: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any reqN_valid, grant one requester. Only one valid: that one. Both valid: the one not equal to last_grant.
  - Assert the granted reqN_ready combinationally in this cycle.
  - Capture addr/write/wdata into registers; update last_grant; go to SETUP.
  - Ready is never asserted outside IDLE.
- SETUP (1 cycle): pselx=1, penable=0; go to ACCESS.
- ACCESS:
  - pselx=1, penable=1; timeout counter increments each cycle.
  - apb_pready=1: completion with err=apb_pslverr and rdata=(write?0:apb_prdata).
  - Else if TOUT_CYC!=0 and counter==TOUT_CYC-1: completion with err=1, rdata=0.
  - Completion -> IDLE; counter clears.
- PREADY wins over timeout in the same cycle.
- apb_paddr/pwrite/pwdata are driven from capture registers, stable through SETUP and ACCESS, and hold their last value in IDLE. pselx/penable are 0 in IDLE.
- Response: registered; rspN_valid high exactly one cycle, the cycle after completion, only for the granted N. rdata/err valid with it; rdata/err return to 0 when not valid.
- Latency: accept at T, SETUP T+1, ACCESS T+2, zero-wait pready at T+2 -> rsp at T+3. A new accept is possible at T+3, giving 3 cycles minimum per transfer. Wait states add 1 cycle each.
- Requester valid dropping after accept has no effect. Valid held without ready is allowed; the command must be held stable by the requester.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2), timeout counter width = clog2(TOUT_CYC+1).
- One sub-module: sirv_apb_rr_arb2, the 2-way round-robin grant with a last_grant register, updated on accept.

Test Plan:
- Single read: req0 read addr 0x10, pready=1 at first ACCESS, prdata=0xA5A5_0001 -> req0_ready at T, pselx T+1..T+2, penable T+2, rsp0_valid T+3 with rdata 0xA5A5_0001, err 0.
- Contention: req0 and req1 both valid continuously, 4 transfers -> grant order 0,1,0,1; each transfer 3 cycles; no rsp to the non-granted requester.
- Wait states and error: req1 write 0x20/0xDEAD_BEEF, pready low 5 ACCESS cycles, then pready=1 with pslverr=1 -> paddr/pwdata stable throughout; rsp1 err=1, rdata=0.
- Timeout: TOUT_CYC=4, pready held 0 -> exactly 4 ACCESS cycles, then IDLE; rsp err=1 and rdata=0.
- Timeout/PREADY collision: pready=1 on the 4th ACCESS cycle with TOUT_CYC=4 -> normal completion, err=pslverr (0).
- Reset mid-ACCESS: assert rst during ACCESS -> next cycle pselx=penable=0, no rsp; first post-reset tie goes to req0.
